mem_arbiter_n: RTL and testbench
================================

# mem_arbiter_n

Parametrised N-port memory arbiter that replaces the two-client instruction/data arbiter in front of the single-port 16-bit program/data memory. It accepts one read or write per cycle from any of N_PORTS requesters, using fixed-priority or round-robin arbitration. It registers the winning command onto the memory bus and routes returning read data back to the issuing port after a fixed memory latency. It sits between the pipeline stages (fetch, execute/mem, future DMA or debug port) and the external memory interface of the cpu top.

## Interface
- N_PORTS, 2: number of requesters, legal 2..8.
- ADDR_WIDTH, 8: memory word address width.
- DATA_WIDTH, 16: memory data width.
- READ_LATENCY, 1: cycles from registered mem_rd_en_o to valid mem_value_i, legal 1..4.
- ARB_MODE, 0: 0 = fixed priority (port 0 highest), 1 = round-robin.

- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  reset; one clock, reset is asynchronous and active-low.
- req_i  input  N_PORTS  per-port access request.
- we_i  input  N_PORTS  per-port write strobe, 1 = write, 0 = read; valid while req_i is high.
- addr_i  input  N_PORTS*ADDR_WIDTH  per-port address; port p uses slice [p*ADDR_WIDTH +: ADDR_WIDTH].
- wdata_i  input  N_PORTS*DATA_WIDTH  per-port write data, sliced the same way.
- gnt_o  output  N_PORTS  combinational one-hot accept; at most one bit high.
- rvalid_o  output  N_PORTS  registered one-hot read-data-valid.
- rdata_o  output  DATA_WIDTH  shared read data bus; equals mem_value_i.
- mem_value_i  input  DATA_WIDTH  read data from memory.
- mem_addr_o  output  ADDR_WIDTH  registered memory address.
- mem_value_o  output  DATA_WIDTH  registered memory write data.
- mem_rd_en_o  output  1  registered read enable.
- mem_wr_en_o  output  1  registered write enable.
- mem_enable_o  output  1  mem_rd_en_o | mem_wr_en_o.

## Operation
- Requester protocol: hold req_i[p], we_i[p], address and data stable until the cycle where gnt_o[p]=1. That cycle is the accept. The next cycle is either a new request or deassertion.
- Fixed mode: the lowest-index requesting port wins.
- Round-robin mode: the search starts at pointer rr_ptr and wraps modulo N_PORTS; the first requesting port wins.
  - On any grant to port w, rr_ptr <= (w+1) mod N_PORTS. With no grant, rr_ptr holds.
  - Fairness: a continuously requesting port is granted within N_PORTS cycles.
- On grant, the next rising edge registers the winner's address and write data onto the memory bus. Exactly one of mem_rd_en_o or mem_wr_en_o is then set, per the winner's we_i.
- With no grant, mem_rd_en_o=mem_wr_en_o=0, and mem_addr_o/mem_value_o hold their last value.
- Read tracking: a READ_LATENCY-deep shift pipe carries {valid, port id} for every issued read. The pipe output drives rvalid_o one-hot. Writes do not enter the pipe.
- The arbiter issues one access per cycle with no back-pressure. Reads and writes may be interleaved back to back, and the return order equals the issue order.
- If all req_i=0, gnt_o=0.

## Timing
- Cycle T: req_i[p]=1 and p wins, so gnt_o[p]=1 in cycle T (combinational).
- Cycle T+1: mem_* outputs carry port p's command.
- Read data: mem_value_i is valid, and rvalid_o[p]=1, in cycle T+1+READ_LATENCY. rdata_o is sampled by the port in that same cycle.
- Back-to-back accepted reads produce back-to-back rvalid pulses, one per cycle.
- Reset values: mem_addr_o=0, mem_value_o=0, mem_rd_en_o=0, mem_wr_en_o=0, mem_enable_o=0, rvalid_o=0, rr_ptr=0. gnt_o follows req_i combinationally even during reset.
- Reset asserted mid-operation: in-flight reads are discarded and no rvalid_o is produced for them. A command registered in the same cycle as reset assertion is cleared immediately.
- Simultaneous requests with an rvalid return are independent; a new grant never suppresses a pending rvalid.
- rr_ptr wrap: from N_PORTS-1 it goes to 0.

## Test plan
- Reset then single read: N_PORTS=2, ARB_MODE=0, port 1 reads addr 0x12, memory returns 0xBEEF.
  - Required: gnt_o=2'b10 in T; mem_addr_o=0x12 and mem_rd_en_o=1 in T+1; rvalid_o=2'b10 and rdata_o=0xBEEF in T+2.
- Fixed-priority contention: ports 0 and 1 both request for 3 cycles.
  - Required: port 0 is granted all 3 cycles and port 1 is never granted.
  - Required: port 1 is granted in the cycle after port 0 drops.
- Round-robin fairness: N_PORTS=4, ARB_MODE=1, all ports request continuously.
  - Required grant sequence: 0,1,2,3,0,1...
  - Required: rr_ptr wraps to 0 after the port-3 grant.
- Mixed read/write with latency: READ_LATENCY=3.
  - Stimulus: port 0 writes 0xA5A5 to 0x40, then port 1 reads 0x40 in the next cycle.
  - Required: mem_wr_en_o=1 then mem_rd_en_o=1 on consecutive cycles; rvalid_o[1]=1 exactly 4 cycles after its grant; no rvalid for the write.
- Reset mid-flight: READ_LATENCY=2, issue a read, then assert rst_i low one cycle after the grant.
  - Required: all mem outputs and rvalid_o go to 0 immediately, and no rvalid_o pulse appears after reset is released.
- Idle hold: after a write to 0x33 with data 0x1234, all req_i=0 for 5 cycles.
  - Required: mem_addr_o=0x33 and mem_value_o=0x1234 hold; mem_rd_en_o=mem_wr_en_o=mem_enable_o=0; gnt_o=0.

Source files
------------

// File: rtl/mem_arbiter_n.sv
// mem_arbiter_n: N-port fixed-priority/round-robin arbiter onto a single-port memory,
// with read data steered back to the issuing port after a fixed memory latency.
module mem_arbiter_n #(
  parameter int N_PORTS      = 2,
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 16,
  parameter int READ_LATENCY = 1,
  parameter int ARB_MODE     = 0
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [N_PORTS-1:0]               req_i,
  input  logic [N_PORTS-1:0]               we_i,
  input  logic [N_PORTS*ADDR_WIDTH-1:0]    addr_i,
  input  logic [N_PORTS*DATA_WIDTH-1:0]    wdata_i,
  output logic [N_PORTS-1:0]               gnt_o,
  output logic [N_PORTS-1:0]               rvalid_o,
  output logic [DATA_WIDTH-1:0]            rdata_o,
  input  logic [DATA_WIDTH-1:0]            mem_value_i,
  output logic [ADDR_WIDTH-1:0]            mem_addr_o,
  output logic [DATA_WIDTH-1:0]            mem_value_o,
  output logic                             mem_rd_en_o,
  output logic                             mem_wr_en_o,
  output logic                             mem_enable_o
);
  localparam int            PW   = $clog2(N_PORTS);
  localparam logic [PW:0]   NP   = (PW+1)'(N_PORTS);
  localparam logic [PW-1:0] LAST = PW'(N_PORTS - 1);
  logic [PW-1:0]         rr_q, rr_d, win, id_q, id_d;
  logic                  any;
  logic [PW:0]           s;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  rd_q, rd_d, wr_q, wr_d;
  logic                  vld_q [READ_LATENCY];
  logic [PW-1:0]         pid_q [READ_LATENCY];
  // Scan ports starting at rr_q (round-robin) or 0 (fixed), wrapping modulo N_PORTS
  always_comb begin
    any = 1'b0;
    win = '0;
    s   = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      s = (ARB_MODE != 0) ? {1'b0, rr_q} + (PW+1)'(i) : (PW+1)'(i);
      s = (s >= NP) ? s - NP : s;
      if (!any && req_i[s[PW-1:0]]) begin
        any = 1'b1;
        win = s[PW-1:0];
      end
    end
  end
  always_comb begin
    gnt_o  = any ? (N_PORTS'(1) << win) : '0;
    rr_d   = any ? ((win == LAST) ? '0 : win + PW'(1)) : rr_q;
    rd_d   = any & ~we_i[win];
    wr_d   = any & we_i[win];
    id_d   = any ? win : id_q;
    addr_d = addr_q;
    data_d = data_q;
    for (int p = 0; p < N_PORTS; p++) begin
      if (any && win == PW'(p)) begin
        addr_d = addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
        data_d = wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rr_q   <= '0;
      id_q   <= '0;
      addr_q <= '0;
      data_q <= '0;
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        vld_q[i] <= 1'b0;
        pid_q[i] <= '0;
      end
    end else begin
      rr_q     <= rr_d;
      id_q     <= id_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      vld_q[0] <= rd_q;
      pid_q[0] <= id_q;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        pid_q[i] <= pid_q[i-1];
      end
    end
  end
  assign rvalid_o     = vld_q[READ_LATENCY-1] ? (N_PORTS'(1) << pid_q[READ_LATENCY-1]) : '0;
  assign rdata_o      = mem_value_i;
  assign mem_addr_o   = addr_q;
  assign mem_value_o  = data_q;
  assign mem_rd_en_o  = rd_q;
  assign mem_wr_en_o  = wr_q;
  assign mem_enable_o = rd_q | wr_q;
endmodule

// File: tb/tb_mem_arbiter_n.sv
// tb_mem_arbiter_n: directed bench over three arbiter configurations with a read-return scoreboard.
module tb_mem_arbiter_n;
  typedef struct {
    int          due;
    int          port;
    logic [15:0] data;
  } exp_t;
  logic clk, rst_n, rst_c;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic [1:0]  a_req, a_we, a_gnt, a_rv;
  logic [15:0] a_addr, a_rd, a_mvi, a_mval;
  logic [31:0] a_wd;
  logic [7:0]  a_maddr;
  logic        a_rden, a_wren, a_en;
  logic [3:0]  b_req, b_we, b_gnt, b_rv;
  logic [31:0] b_addr;
  logic [63:0] b_wd;
  logic [15:0] b_rd, b_mvi, b_mval;
  logic [7:0]  b_maddr;
  logic        b_rden, b_wren, b_en;
  logic [1:0]  c_req, c_we, c_gnt, c_rv;
  logic [15:0] c_addr, c_rd, c_mvi, c_mval;
  logic [31:0] c_wd;
  logic [7:0]  c_maddr;
  logic        c_rden, c_wren, c_en;
  logic [15:0] mem_a [256];
  logic [15:0] mem_b [256];
  exp_t qa[$], qb[$], ra[$], rb[$];
  exp_t ea, eb, xa, xb;
  mem_arbiter_n #(.N_PORTS(2), .READ_LATENCY(1), .ARB_MODE(0)) u_a (
    .clk_i(clk), .rst_i(rst_n), .req_i(a_req), .we_i(a_we), .addr_i(a_addr), .wdata_i(a_wd),
    .gnt_o(a_gnt), .rvalid_o(a_rv), .rdata_o(a_rd), .mem_value_i(a_mvi), .mem_addr_o(a_maddr),
    .mem_value_o(a_mval), .mem_rd_en_o(a_rden), .mem_wr_en_o(a_wren), .mem_enable_o(a_en));
  mem_arbiter_n #(.N_PORTS(4), .READ_LATENCY(3), .ARB_MODE(1)) u_b (
    .clk_i(clk), .rst_i(rst_n), .req_i(b_req), .we_i(b_we), .addr_i(b_addr), .wdata_i(b_wd),
    .gnt_o(b_gnt), .rvalid_o(b_rv), .rdata_o(b_rd), .mem_value_i(b_mvi), .mem_addr_o(b_maddr),
    .mem_value_o(b_mval), .mem_rd_en_o(b_rden), .mem_wr_en_o(b_wren), .mem_enable_o(b_en));
  mem_arbiter_n #(.N_PORTS(2), .READ_LATENCY(2), .ARB_MODE(0)) u_c (
    .clk_i(clk), .rst_i(rst_c), .req_i(c_req), .we_i(c_we), .addr_i(c_addr), .wdata_i(c_wd),
    .gnt_o(c_gnt), .rvalid_o(c_rv), .rdata_o(c_rd), .mem_value_i(c_mvi), .mem_addr_o(c_maddr),
    .mem_value_o(c_mval), .mem_rd_en_o(c_rden), .mem_wr_en_o(c_wren), .mem_enable_o(c_en));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic exp_t mk(input int due, input int port, input logic [15:0] data);
    exp_t e;
    e.due  = due;
    e.port = port;
    e.data = data;
    return e;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // Memory models: writes land at once, read data appears READ_LATENCY cycles after rd_en
  always @(negedge clk) begin
    if (a_wren) mem_a[a_maddr] = a_mval;
    if (a_rden) ra.push_back(mk(cyc + 1, 0, mem_a[a_maddr]));
    if (b_wren) mem_b[b_maddr] = b_mval;
    if (b_rden) rb.push_back(mk(cyc + 3, 0, mem_b[b_maddr]));
  end
  always @(posedge clk) begin
    #1;
    if (ra.size() > 0 && ra[0].due == cyc) begin xa = ra.pop_front(); a_mvi = xa.data; end
    else a_mvi = 16'h0;
    if (rb.size() > 0 && rb[0].due == cyc) begin xb = rb.pop_front(); b_mvi = xb.data; end
    else b_mvi = 16'h0;
  end
  always @(negedge clk) begin
    if (qa.size() > 0 && qa[0].due == cyc) begin
      ea = qa.pop_front();
      chk("a_rvalid", 32'(a_rv), 32'd1 << ea.port);
      chk("a_rdata", 32'(a_rd), 32'(ea.data));
    end else if (a_rv !== 2'b00) chk("a_spurious_rvalid", 32'(a_rv), 32'd0);
    if (qb.size() > 0 && qb[0].due == cyc) begin
      eb = qb.pop_front();
      chk("b_rvalid", 32'(b_rv), 32'd1 << eb.port);
      chk("b_rdata", 32'(b_rd), 32'(eb.data));
    end else if (b_rv !== 4'b0000) chk("b_spurious_rvalid", 32'(b_rv), 32'd0);
  end
  initial begin
    clk = 0; rst_n = 0; rst_c = 0;
    a_req = 0; a_we = 0; a_addr = 0; a_wd = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wd = 0;
    c_req = 0; c_we = 0; c_addr = 0; c_wd = 0; c_mvi = 16'hC0DE;
    a_mvi = 0; b_mvi = 0;
    for (int i = 0; i < 256; i++) begin mem_a[i] = 16'h0; mem_b[i] = 16'h0; end
    mem_a[8'h12] = 16'hBEEF;
    mem_a[8'h50] = 16'h5A5A;
    for (int p = 0; p < 4; p++) mem_b[8'h60 + p] = 16'hB000 + 16'(p);
    tick();
    a_req = 2'b10;
    #1 chk("a_gnt_in_reset", 32'(a_gnt), 32'h2);
    a_req = 2'b00;
    @(negedge clk);
    chk("rst_maddr", 32'(a_maddr), 0);
    chk("rst_mval", 32'(a_mval), 0);
    chk("rst_rden", 32'(a_rden), 0);
    chk("rst_wren", 32'(a_wren), 0);
    chk("rst_en", 32'(a_en), 0);
    chk("rst_rvalid", 32'(a_rv), 0);
    chk("rst_b_en", 32'(b_en), 0);
    tick();
    rst_n = 1; rst_c = 1;
    // single read by port 1
    tick();
    a_req = 2'b10; a_we = 2'b00; a_addr[8 +: 8] = 8'h12;
    qa.push_back(mk(cyc + 2, 1, 16'hBEEF));
    @(negedge clk) chk("rd1_gnt", 32'(a_gnt), 32'h2);
    tick();
    a_req = 2'b00;
    @(negedge clk);
    chk("rd1_maddr", 32'(a_maddr), 32'h12);
    chk("rd1_rden", 32'(a_rden), 1);
    chk("rd1_wren", 32'(a_wren), 0);
    chk("rd1_en", 32'(a_en), 1);
    tick();
    // back-to-back reads from both ports
    tick();
    a_req = 2'b01; a_addr[0 +: 8] = 8'h12;
    qa.push_back(mk(cyc + 2, 0, 16'hBEEF));
    @(negedge clk) chk("b2b_gnt0", 32'(a_gnt), 32'h1);
    tick();
    a_req = 2'b10; a_addr[8 +: 8] = 8'h50;
    qa.push_back(mk(cyc + 2, 1, 16'h5A5A));
    @(negedge clk) chk("b2b_gnt1", 32'(a_gnt), 32'h2);
    tick();
    a_req = 2'b00;
    tick();
    tick();
    // fixed-priority contention with writes
    tick();
    a_req = 2'b11; a_we = 2'b11;
    a_addr = {8'h21, 8'h20}; a_wd = {16'h2222, 16'h1111};
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      @(negedge clk) chk("fix_gnt0", 32'(a_gnt), 32'h1);
      if (i > 0) chk("fix_maddr0", 32'(a_maddr), 32'h20);
    end
    tick();
    a_req = 2'b10;
    @(negedge clk) chk("fix_gnt1", 32'(a_gnt), 32'h2);
    tick();
    a_req = 2'b00;
    @(negedge clk);
    chk("fix_maddr1", 32'(a_maddr), 32'h21);
    chk("fix_mval1", 32'(a_mval), 32'h2222);
    chk("fix_wren1", 32'(a_wren), 1);
    // idle hold after a write
    tick();
    a_req = 2'b01; a_we = 2'b01; a_addr[0 +: 8] = 8'h33; a_wd[0 +: 16] = 16'h1234;
    @(negedge clk) chk("hold_gnt", 32'(a_gnt), 32'h1);
    tick();
    a_req = 2'b00; a_we = 2'b00;
    @(negedge clk);
    chk("hold_wren_issue", 32'(a_wren), 1);
    chk("hold_maddr_issue", 32'(a_maddr), 32'h33);
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      chk("hold_gnt0", 32'(a_gnt), 0);
      chk("hold_maddr", 32'(a_maddr), 32'h33);
      chk("hold_mval", 32'(a_mval), 32'h1234);
      chk("hold_rden", 32'(a_rden), 0);
      chk("hold_wren", 32'(a_wren), 0);
      chk("hold_en", 32'(a_en), 0);
    end
    // round-robin fairness, four ports requesting continuously
    tick();
    b_req = 4'hF; b_we = 4'h0; b_addr = {8'h63, 8'h62, 8'h61, 8'h60};
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      qb.push_back(mk(cyc + 4, i % 4, 16'hB000 + 16'(i % 4)));
      @(negedge clk) chk("rr_gnt", 32'(b_gnt), 32'd1 << (i % 4));
    end
    tick();
    b_req = 4'h0;
    tick();
    tick();
    // pointer held at 2 while idle: port 3 beats port 0, then wraps to port 0
    tick();
    b_req = 4'b1001;
    qb.push_back(mk(cyc + 4, 3, 16'hB003));
    @(negedge clk) chk("rr_hold_gnt3", 32'(b_gnt), 32'h8);
    tick();
    qb.push_back(mk(cyc + 4, 0, 16'hB000));
    @(negedge clk) chk("rr_wrap_gnt0", 32'(b_gnt), 32'h1);
    tick();
    b_req = 4'h0;
    // write then read of the same address with latency 3
    tick();
    b_req = 4'b0001; b_we = 4'b0001; b_addr[0 +: 8] = 8'h40; b_wd[0 +: 16] = 16'hA5A5;
    @(negedge clk) chk("mix_gnt_w", 32'(b_gnt), 32'h1);
    tick();
    b_req = 4'b0010; b_we = 4'b0000; b_addr[8 +: 8] = 8'h40;
    qb.push_back(mk(cyc + 4, 1, 16'hA5A5));
    @(negedge clk);
    chk("mix_gnt_r", 32'(b_gnt), 32'h2);
    chk("mix_wren", 32'(b_wren), 1);
    chk("mix_rden_w", 32'(b_rden), 0);
    chk("mix_maddr_w", 32'(b_maddr), 32'h40);
    chk("mix_mval_w", 32'(b_mval), 32'hA5A5);
    tick();
    b_req = 4'h0;
    @(negedge clk);
    chk("mix_rden", 32'(b_rden), 1);
    chk("mix_wren_r", 32'(b_wren), 0);
    chk("mix_maddr_r", 32'(b_maddr), 32'h40);
    for (int i = 0; i < 6; i++) tick();
    // reset asserted while a read is in flight
    tick();
    c_req = 2'b01; c_we = 2'b00; c_addr[0 +: 8] = 8'h05;
    @(negedge clk) chk("mid_gnt", 32'(c_gnt), 32'h1);
    tick();
    c_req = 2'b00;
    chk("mid_rden_pre", 32'(c_rden), 1);
    chk("mid_maddr_pre", 32'(c_maddr), 32'h05);
    rst_c = 0;
    #1;
    chk("mid_maddr", 32'(c_maddr), 0);
    chk("mid_mval", 32'(c_mval), 0);
    chk("mid_rden", 32'(c_rden), 0);
    chk("mid_wren", 32'(c_wren), 0);
    chk("mid_en", 32'(c_en), 0);
    chk("mid_rvalid", 32'(c_rv), 0);
    tick();
    tick();
    rst_c = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      @(negedge clk) chk("mid_no_rvalid", 32'(c_rv), 0);
    end
    tick();
    tick();
    chk("a_scoreboard_empty", 32'(qa.size()), 0);
    chk("b_scoreboard_empty", 32'(qb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
